// File: rtl/fft_frame_arbiter.sv
// Purpose : shares the FFT pipeline between two sample sources, one FRAME_LEN frame at a time, and tags each frame's channel.
// Latency : grant 1 cycle after request in IDLE; accepted sample appears on fft_* 1 cycle after handshake; out_* are combinational.
// Backpr. : only the granted source sees ready; no grant while the tag FIFO is full. Build option FFT_ARB_FIXED_PRIO_EN = ch0 always wins ties.
module fft_frame_arbiter #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic signed [DATA_W-1:0] req0_r,
    input  logic signed [DATA_W-1:0] req0_i,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic signed [DATA_W-1:0] req1_r,
    input  logic signed [DATA_W-1:0] req1_i,
    output logic                     fft_valid_o,
    output logic signed [DATA_W-1:0] fft_r,
    output logic signed [DATA_W-1:0] fft_i,
    input  logic                     pipe_valid_i,
    output logic                     out_ch,
    output logic                     out_first,
    output logic                     out_last,
    output logic                     busy,
    output logic                     orphan_err
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_LEN - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(TAG_DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic             gnt;
    logic             last;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;

    logic             tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] tag_occ;

    logic tag_full;
    logic tag_empty;
    logic pick1;
    logic grant;
    logic hs;
    logic push;
    logic pop;

    assign tag_full  = (tag_occ == OCC_FULL);
    assign tag_empty = (tag_occ == '0);

`ifdef FFT_ARB_FIXED_PRIO_EN
    assign pick1 = req1_valid && !req0_valid;
`else
    // On a tie, serve the channel that was not served last.
    assign pick1 = req1_valid && (!req0_valid || !last);
`endif

    assign grant = (state == IDLE) && (req0_valid || req1_valid) && !tag_full;
    assign hs    = (req0_ready && req0_valid) || (req1_ready && req1_valid);
    assign push  = grant;
    assign pop   = pipe_valid_i && !tag_empty && (out_cnt == CNT_MAX);

    assign out_ch    = tag_empty ? 1'b0 : tag_mem[rd_ptr];
    assign out_first = pipe_valid_i && !tag_empty && (out_cnt == '0);
    assign out_last  = pipe_valid_i && !tag_empty && (out_cnt == CNT_MAX);

    // Grant FSM: IDLE picks a source, BUSY holds it for exactly FRAME_LEN handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            last       <= 1'b1;
            in_cnt     <= '0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state      <= BUSY;
                        gnt        <= pick1;
                        in_cnt     <= '0;
                        req0_ready <= !pick1;
                        req1_ready <= pick1;
                        busy       <= 1'b1;
                    end
                end
                BUSY: begin
                    if (hs) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == CNT_MAX) begin
                            state      <= IDLE;
                            last       <= gnt;
                            req0_ready <= 1'b0;
                            req1_ready <= 1'b0;
                            busy       <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register accepted samples bit-exact into stage 1; data holds during gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fft_valid_o <= 1'b0;
            fft_r       <= '0;
            fft_i       <= '0;
        end else begin
            fft_valid_o <= hs;
            if (hs) begin
                fft_r <= gnt ? req1_r : req0_r;
                fft_i <= gnt ? req1_i : req0_i;
            end
        end
    end

    // Tag storage; the head is only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= pick1;
        end
    end

    // Tag FIFO pointers, outgoing sample counter and sticky orphan flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tag_occ    <= '0;
            out_cnt    <= '0;
            orphan_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      tag_occ <= tag_occ + 1'b1;
            else if (pop && !push) tag_occ <= tag_occ - 1'b1;
            if (pipe_valid_i) begin
                if (tag_empty) orphan_err <= 1'b1;
                else           out_cnt    <= out_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Purpose : directed, table-driven check of fft_frame_arbiter grant, data, tag and reset behaviour.
// Latency : inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the following edge.
// Backpr. : the bench drives valids and checks the readies the arbiter should present.
module tb_fft_frame_arbiter;

    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 32;

    logic clk;
    logic rst;
    logic req0_valid, req1_valid;
    logic req0_ready, req1_ready;
    logic signed [DATA_W-1:0] req0_r, req0_i, req1_r, req1_i;
    logic fft_valid_o;
    logic signed [DATA_W-1:0] fft_r, fft_i;
    logic pipe_valid_i;
    logic out_ch, out_first, out_last, busy, orphan_err;

    int total;
    int bad;

    fft_frame_arbiter #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .TAG_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_r(req0_r), .req0_i(req0_i),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_r(req1_r), .req1_i(req1_i),
        .fft_valid_o(fft_valid_o), .fft_r(fft_r), .fft_i(fft_i),
        .pipe_valid_i(pipe_valid_i), .out_ch(out_ch), .out_first(out_first), .out_last(out_last),
        .busy(busy), .orphan_err(orphan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One frame request pattern and the channel expected to win it.
    typedef struct {
        bit v0;
        bit v1;
        bit exp_ch;
        int gap_at;
        int gap_len;
    } rec_t;

    rec_t tbl [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_data(input int v);
        req0_r = DATA_W'(v);
        req1_r = DATA_W'(v);
        req0_i = ~DATA_W'(v);
        req1_i = ~DATA_W'(v);
    endtask

    // Request a frame starting in IDLE and follow it to the end.
    task automatic run_frame(input rec_t r, input int base);
        int  n;
        int  g;
        int  cyc;
        bit  drop;
        bit  vexp;
        logic win_rdy, lose_rdy;
        n = 0; g = 0; cyc = 0;
        req0_valid = r.v0;
        req1_valid = r.v1;
        drive_data(base);
        step();
        win_rdy  = r.exp_ch ? req1_ready : req0_ready;
        lose_rdy = r.exp_ch ? req0_ready : req1_ready;
        chk("grant_ready", {31'd0, win_rdy}, 32'd1);
        chk("loser_ready_at_grant", {31'd0, lose_rdy}, 32'd0);
        chk("busy_at_grant", {31'd0, busy}, 32'd1);
        chk("no_valid_at_grant", {31'd0, fft_valid_o}, 32'd0);
        while (n < FRAME_LEN && cyc < 200) begin
            drop = (n == r.gap_at) && (g < r.gap_len);
            if (drop) g++;
            vexp = !drop;
            if (r.exp_ch) begin
                req1_valid = vexp;
                req0_valid = r.v0;
            end else begin
                req0_valid = vexp;
                req1_valid = r.v1;
            end
            drive_data(base + n);
            step();
            cyc++;
            chk("fft_valid", {31'd0, fft_valid_o}, {31'd0, vexp});
            if (vexp) begin
                chk("fft_r", {16'd0, fft_r}, {16'd0, DATA_W'(base + n)});
                chk("fft_i", {16'd0, fft_i}, {16'd0, ~DATA_W'(base + n)});
                n++;
            end
            win_rdy  = r.exp_ch ? req1_ready : req0_ready;
            lose_rdy = r.exp_ch ? req0_ready : req1_ready;
            chk("loser_ready", {31'd0, lose_rdy}, 32'd0);
            if (n < FRAME_LEN) chk("grant_held", {31'd0, win_rdy}, 32'd1);
        end
        chk("frame_handshakes", n, FRAME_LEN);
        chk("ready_drop_after_frame", {31'd0, win_rdy}, 32'd0);
        chk("busy_low_after_frame", {31'd0, busy}, 32'd0);
    endtask

    // Present one frame's worth of last-stage valids and check the decode.
    task automatic drain(input bit exp_ch);
        for (int k = 0; k < FRAME_LEN; k++) begin
            pipe_valid_i = 1'b1;
            #1;
            chk("out_first", {31'd0, out_first}, {31'd0, (k == 0)});
            chk("out_last", {31'd0, out_last}, {31'd0, (k == FRAME_LEN - 1)});
            chk("out_ch", {31'd0, out_ch}, {31'd0, exp_ch});
            step();
        end
        pipe_valid_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req0_ready"}, {31'd0, req0_ready}, 32'd0);
        chk({tag, "_req1_ready"}, {31'd0, req1_ready}, 32'd0);
        chk({tag, "_fft_valid"}, {31'd0, fft_valid_o}, 32'd0);
        chk({tag, "_fft_r"}, {16'd0, fft_r}, 32'd0);
        chk({tag, "_fft_i"}, {16'd0, fft_i}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_out_first"}, {31'd0, out_first}, 32'd0);
        chk({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
        chk({tag, "_out_ch"}, {31'd0, out_ch}, 32'd0);
        chk({tag, "_orphan"}, {31'd0, orphan_err}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; pipe_valid_i = 1'b0;
        drive_data(0);

        // single source, tie 0 then 1 then 0, then ch1 with a 5-cycle gap
        tbl[0] = '{v0: 1'b1, v1: 1'b0, exp_ch: 1'b0, gap_at: -1, gap_len: 0};
`ifdef FFT_ARB_FIXED_PRIO_EN
        tbl[1] = '{v0: 1'b1, v1: 1'b1, exp_ch: 1'b0, gap_at: -1, gap_len: 0};
`else
        tbl[1] = '{v0: 1'b1, v1: 1'b1, exp_ch: 1'b1, gap_at: -1, gap_len: 0};
`endif
        tbl[2] = '{v0: 1'b1, v1: 1'b1, exp_ch: 1'b0, gap_at: -1, gap_len: 0};
        tbl[3] = '{v0: 1'b0, v1: 1'b1, exp_ch: 1'b1, gap_at: 10, gap_len: 5};

        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        check_all_zero("idle");

        for (int i = 0; i < 4; i++) begin
            run_frame(tbl[i], i * 64 + 1);
        end

        // four tags in flight: further requests must wait
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_no_ready", {31'd0, req0_ready}, 32'd0);
            chk("full_not_busy", {31'd0, busy}, 32'd0);
        end
        chk("out_first_unqualified", {31'd0, out_first}, 32'd0);

        drain(tbl[0].exp_ch);
        chk("pop_edge_still_idle", {31'd0, busy}, 32'd0);
        run_frame('{v0: 1'b1, v1: 1'b0, exp_ch: 1'b0, gap_at: -1, gap_len: 0}, 1000);
        req0_valid = 1'b0;

        drain(tbl[1].exp_ch);
        drain(tbl[2].exp_ch);
        drain(tbl[3].exp_ch);
        drain(1'b0);

        // last-stage valid with nothing in flight
        chk("orphan_before", {31'd0, orphan_err}, 32'd0);
        pipe_valid_i = 1'b1;
        step();
        pipe_valid_i = 1'b0;
        chk("orphan_set", {31'd0, orphan_err}, 32'd1);
        step();
        step();
        chk("orphan_sticky", {31'd0, orphan_err}, 32'd1);

        // reset in the middle of a ch1 frame
        req1_valid = 1'b1;
        step();
        chk("pre_reset_grant", {31'd0, req1_ready}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive_data(500 + i);
            step();
        end
        chk("pre_reset_valid", {31'd0, fft_valid_o}, 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        step();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst = 1'b0;
        step();
        chk("post_reset_tie_ch0", {31'd0, req0_ready}, 32'd1);
        chk("post_reset_tie_ch1", {31'd0, req1_ready}, 32'd0);
        chk("post_reset_busy", {31'd0, busy}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/fft_frame_arbiter.md
# fft_frame_arbiter

Frame-level arbiter that shares the 32-point FFT pipeline between two sample sources. It grants one requester at a time for exactly FRAME_LEN accepted samples, then forwards them as a valid-qualified stream into the first pipeline stage. It also tags each frame with its source channel so the frame can be identified when it leaves the last stage. It sits directly in front of stage 1 and observes the last stage's output valid.

## Interface
- DATA_W, 16: width of each real/imag sample component (signed)
- FRAME_LEN, 32: samples per FFT frame (power of two)
- TAG_DEPTH, 4: depth of the in-flight channel-tag FIFO (power of two)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  channel 0 sample valid
- req0_ready  out  1  channel 0 sample accepted this cycle when high with valid
- req0_r / req0_i  in  DATA_W each  channel 0 sample
- req1_valid, req1_ready, req1_r, req1_i: same for channel 1
- fft_valid_o  out  1  sample valid into stage 1
- fft_r / fft_i  out  DATA_W each  sample into stage 1, registered
- pipe_valid_i  in  1  output valid of last FFT stage
- out_ch  out  1  source channel of the frame currently leaving the pipeline
- out_first / out_last  out  1  first / last sample of the outgoing frame (qualified by pipe_valid_i)
- busy  out  1  a frame is being granted
- orphan_err  out  1  sticky: pipe_valid_i seen with tag FIFO empty

## Operation
- FSM states: IDLE, BUSY. Registers: grant channel `gnt`, last-served pointer `last`, input counter `in_cnt` (log2 FRAME_LEN bits).
- IDLE: if any reqN_valid and tag FIFO not full -> BUSY. Choose requester: only one valid -> that one; both -> the channel != `last`. Set `gnt`, push `gnt` into the tag FIFO, clear `in_cnt`. Both readies are low in IDLE.
- BUSY: req[gnt]_ready = 1, other ready = 0. Each handshake increments `in_cnt`. A stalled granted channel (valid low) produces gap cycles with fft_valid_o = 0. The grant is held; no timeout applies.
- When the handshake occurs with in_cnt = FRAME_LEN-1: `last` <= gnt, `in_cnt` wraps to 0, next state is IDLE. There is always at least one idle bubble between frames.
- The tag FIFO is full in IDLE: no grant, readies stay low, and requests wait.
- Output side: out counter `out_cnt` counts pipe_valid_i. out_ch = FIFO head, out_first = (out_cnt == 0), out_last = (out_cnt == FRAME_LEN-1). On pipe_valid_i with out_last, pop the FIFO and wrap `out_cnt` to 0.
- If a push and a pop occur in the same cycle, both take effect and the FIFO occupancy is unchanged.
- pipe_valid_i with the FIFO empty: set orphan_err, no pop, and `out_cnt` is unchanged.
- No arithmetic is performed on data; samples pass through bit-exact.

## Timing
- Reset values: all readies 0, fft_valid_o 0, fft_r/fft_i 0, busy 0, out_first 0, out_last 0, out_ch 0, orphan_err 0. After reset: FSM = IDLE, `last` = 1 (so channel 0 wins the first tie), FIFO empty, counters 0.
- Grant latency: valid rises at cycle t in IDLE -> BUSY at t+1 -> ready high at t+1.
- Data latency: a handshake at cycle t appears on fft_* with fft_valid_o at t+1.
- busy is high exactly while FSM = BUSY.
- Reset mid-frame clears everything immediately: partial frames and in-flight tags are dropped.
- out_* are combinational from FIFO head and `out_cnt`; there is no added latency relative to pipe_valid_i.

## Configuration
- FFT_ARB_FIXED_PRIO_EN defined: channel 0 always wins a tie in IDLE, and `last` is ignored (channel 1 can be starved).
- FFT_ARB_FIXED_PRIO_EN not defined: round-robin as described under Operation.

## Test plan
- Single source: ch0 streams 32 samples 1..32 continuously. Expected: ready high for 32 cycles starting 1 cycle after valid; fft_r = 1..32 one cycle later; then 1 idle cycle; busy low.
- Tie, round-robin: both valid held high for 3 frames. Expected grant order 0,1,0; each frame exactly 32 handshakes; losing ready stays 0.
- Gaps: granted ch1 drops valid for 5 cycles mid-frame. Expected: fft_valid_o low for 5 cycles; grant held; frame completes after 32 accepted samples.
- Tag FIFO: grant 4 frames with pipe_valid_i low. Expected: 5th request gets no ready. Then 32 pipe_valid_i pulses -> out_first on pulse 1, out_last on pulse 32, out_ch = first frame's channel; the blocked grant proceeds the next cycle.
- Orphan and reset: pipe_valid_i with FIFO empty -> orphan_err = 1 and sticky. Assert rst at sample 10 of a frame -> all outputs 0, next request re-granted from IDLE, channel 0 wins the tie.
- With FFT_ARB_FIXED_PRIO_EN: both valid for 2 frames -> grants 0,0.
